// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
// Sequential SHA-256 message-schedule generator. A 512-bit block is loaded
// as 16 big-endian words into a 16-entry sliding window; the window then
// shifts once per accepted output word. The word at the head is always the
// next schedule word, and the word entering the tail is produced by the
// expansion recurrence. W[0..15] therefore leave the block unchanged, and
// W[16..63] are generated on the fly, with no separate path for t < 16.
module sha256_msg_schedule #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_word,
    output logic [5:0]        w_index,
    output logic              busy,
    output logic              done
);

    localparam int         WIN_DEPTH = 16;
    localparam logic [5:0] LAST_IDX  = 6'(NUM_WORDS - 1);
    localparam logic [3:0] LAST_LOAD = 4'(WIN_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_LOAD   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        logic [31:0] r7;
        logic [31:0] r18;
        logic [31:0] s3;
        r7  = {x[6:0],  x[31:7]};
        r18 = {x[17:0], x[31:18]};
        s3  = {3'b000,  x[31:3]};
        return r7 ^ r18 ^ s3;
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        logic [31:0] r17;
        logic [31:0] r19;
        logic [31:0] s10;
        r17 = {x[16:0], x[31:17]};
        r19 = {x[18:0], x[31:19]};
        s10 = {10'b00_0000_0000, x[31:10]};
        return r17 ^ r19 ^ s10;
    endfunction

    // Control state and registered outputs
    state_e      state_q,    state_d;
    logic [3:0]  load_cnt_q, load_cnt_d;
    logic [5:0]  round_q,    round_d;
    logic        in_ready_q, in_ready_d;
    logic        w_valid_q,  w_valid_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;

    // Sliding window: win_q[0] is W[t], win_q[k] is W[t+k]
    logic [WORD_W-1:0] win_q [WIN_DEPTH];
    logic [WORD_W-1:0] win_d [WIN_DEPTH];

    logic              in_hs_s;
    logic              w_hs_s;
    logic              load_wr_s;
    logic              shift_s;
    logic [WORD_W-1:0] expand_s;

    // Handshake qualifiers use only registered ready/valid, so no input
    // ever reaches in_ready or w_valid combinationally.
    always_comb begin
        in_hs_s   = in_valid & in_ready_q;
        w_hs_s    = w_valid_q & w_ready;
        load_wr_s = (state_q == ST_LOAD) & in_hs_s;
        shift_s   = (state_q == ST_STREAM) & w_hs_s;
    end

    // Expansion term that enters the window tail: W[t+16] from W[t..t+14]
    always_comb begin
        expand_s = small_sigma1(win_q[14]) + win_q[9]
                 + small_sigma0(win_q[1]) + win_q[0];
    end

    // Window next state: capture during load, shift during stream, else hold
    always_comb begin
        for (int i = 0; i < WIN_DEPTH; i++) begin
            win_d[i] = win_q[i];
        end
        if (load_wr_s) begin
            win_d[load_cnt_q] = in_word;
        end else if (shift_s) begin
            for (int i = 0; i < WIN_DEPTH - 1; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[WIN_DEPTH - 1] = expand_s;
        end else begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win_d[i] = win_q[i];
            end
        end
    end

    // Control next state: load counting, round counting and output flags
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        round_d    = round_q;
        in_ready_d = in_ready_q;
        w_valid_d  = w_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (in_hs_s) begin
                    if (load_cnt_q == LAST_LOAD) begin
                        state_d    = ST_STREAM;
                        load_cnt_d = 4'd0;
                        round_d    = 6'd0;
                        in_ready_d = 1'b0;
                        w_valid_d  = 1'b1;
                        busy_d     = 1'b1;
                    end else begin
                        load_cnt_d = load_cnt_q + 4'd1;
                    end
                end else begin
                    load_cnt_d = load_cnt_q;
                end
            end
            ST_STREAM: begin
                if (w_hs_s) begin
                    if (round_q == LAST_IDX) begin
                        state_d    = ST_LOAD;
                        round_d    = 6'd0;
                        in_ready_d = 1'b1;
                        w_valid_d  = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        round_d = round_q + 6'd1;
                    end
                end else begin
                    round_d = round_q;
                end
            end
            default: begin
                // Unreachable encoding: fall back to an idle, ready-to-load state
                state_d    = ST_LOAD;
                load_cnt_d = 4'd0;
                round_d    = 6'd0;
                in_ready_d = 1'b1;
                w_valid_d  = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered handshake/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= 4'd0;
            round_q    <= 6'd0;
            in_ready_q <= 1'b1;
            w_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            round_q    <= round_d;
            in_ready_q <= in_ready_d;
            w_valid_q  <= w_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Window storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win_q[i] <= {WORD_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // Outputs come straight from registers
    assign in_ready = in_ready_q;
    assign w_valid  = w_valid_q;
    assign w_word   = win_q[0];
    assign w_index  = round_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Testbench for sha256_msg_schedule: scoreboard of expected schedule words
// produced by a plain-arithmetic reference of the SHA-256 recurrence, with a
// monitor that pops and compares on every output handshake.
module tb_sha256_msg_schedule;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_word;
    logic [5:0]  w_index;
    logic        busy;
    logic        done;

    sha256_msg_schedule #(.WORD_W(32), .NUM_WORDS(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_word  (in_word),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_word   (w_word),
        .w_index  (w_index),
        .busy     (busy),
        .done     (done)
    );

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] word;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_hs = 0;
    int n_done = 0;
    int done_cyc = 0;
    int stall_seen = 0;
    int cyc = 0;
    bit stall_en = 1'b0;
    int stall_left = 0;

    logic [31:0] abc_blk  [16];
    logic [31:0] ones_blk [16];
    logic [31:0] rnd_a    [16];
    logic [31:0] rnd_b    [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Output handshake monitor / scoreboard checker
    initial begin : monitor
        logic done_exp;
        exp_t e;
        done_exp = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_exp = 1'b0;
            end else begin
                check("done", done, done_exp);
                check("busy_vs_valid", busy, w_valid);
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                    check("in_ready_in_done_cycle", in_ready, 1);
                end
                done_exp = 1'b0;
                if (w_valid && w_ready) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_word: got idx %0d word 0x%08h, expected no output", w_index, w_word);
                    end else begin
                        e = sb_q.pop_front();
                        check("w_index", w_index, e.idx);
                        check("w_word", w_word, e.word);
                        n_hs++;
                        if (e.idx == 6'd63) done_exp = 1'b1;
                    end
                end else if (w_valid && sb_q.size() > 0) begin
                    check("stall_index", w_index, sb_q[0].idx);
                    check("stall_word", w_word, sb_q[0].word);
                    stall_seen++;
                end
            end
        end
    end

    // Consumer ready: held high except a 3-cycle stall at w_index 5
    initial begin
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_en && w_valid && w_index == 6'd5 && stall_left > 0) begin
                w_ready = 1'b0;
                stall_left--;
            end else begin
                w_ready = 1'b1;
            end
        end
    end

    // Push reference words, feed 16 words (optionally with bubbles)
    task automatic load_block(input logic [31:0] blk [16], input int gap_pct,
                              input bit junk, output int first_valid_cyc);
        logic [31:0] w [64];
        exp_t e;
        int n;
        int guard;
        for (int t = 0; t < 16; t++) w[t] = blk[t];
        for (int t = 16; t < 64; t++)
            w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
        for (int t = 0; t < 64; t++) begin
            e.idx  = 6'(t);
            e.word = w[t];
            sb_q.push_back(e);
        end
        n = 0;
        guard = 0;
        while (n < 16 && guard < 400) begin
            @(posedge clk);
            #1;
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_word  = $urandom;
            end else begin
                in_valid = 1'b1;
                in_word  = blk[n];
            end
            @(negedge clk);
            check("load_w_valid_low", w_valid, 0);
            if (in_valid && in_ready) n++;
            guard++;
        end
        if (n < 16) fail_now("load_timeout");
        @(posedge clk);
        #1;
        in_valid = junk;
        in_word  = $urandom;
        @(negedge clk);
        first_valid_cyc = cyc;
        check("w_valid_after_16th", w_valid, 1);
        check("in_ready_low_stream", in_ready, 0);
    endtask

    // Wait until every expected word has been seen, then let done be observed
    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (sb_q.size() != 0) begin
            fail_now("drain_timeout");
            sb_q.delete();
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int fv;
        int d0;
        int h0;
        int s0;
        int k;

        in_valid = 1'b0;
        in_word  = 32'h0;
        rst      = 1'b0;
        for (int i = 0; i < 16; i++) begin
            abc_blk[i]  = 32'h0;
            ones_blk[i] = 32'hFFFF_FFFF;
            rnd_a[i]    = $urandom;
            rnd_b[i]    = $urandom;
        end
        abc_blk[0]  = 32'h6162_6380;
        abc_blk[15] = 32'h0000_0018;

        // Reset values
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_w_valid", w_valid, 0);
        check("rst_w_word", w_word, 0);
        check("rst_w_index", w_index, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;

        // 1: abc block, w_ready high
        d0 = n_done; h0 = n_hs;
        load_block(abc_blk, 0, 1'b0, fv);
        drain(200);
        check("s1_done_count", n_done - d0, 1);
        check("s1_word_count", n_hs - h0, 64);
        check("s1_done_latency", done_cyc - fv, 64);

        // 2: backpressure at w_index 5
        d0 = n_done; h0 = n_hs; s0 = stall_seen;
        stall_left = 3;
        stall_en = 1'b1;
        load_block(abc_blk, 0, 1'b0, fv);
        drain(200);
        stall_en = 1'b0;
        check("s2_stall_cycles", stall_seen - s0, 3);
        check("s2_word_count", n_hs - h0, 64);
        check("s2_done_count", n_done - d0, 1);

        // 3: input bubbles, junk in_valid while streaming
        d0 = n_done; h0 = n_hs;
        load_block(abc_blk, 40, 1'b1, fv);
        drain(200);
        check("s3_word_count", n_hs - h0, 64);
        check("s3_done_count", n_done - d0, 1);

        // 4: all-ones block (carry wrap)
        d0 = n_done;
        load_block(ones_blk, 0, 1'b0, fv);
        drain(200);
        check("s4_done_count", n_done - d0, 1);

        // 5: reset mid-stream at w_index 30
        d0 = n_done;
        load_block(abc_blk, 0, 1'b0, fv);
        k = 0;
        while (!(w_valid && w_index == 6'd30) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) fail_now("s5_wait_index30");
        #2 rst = 1'b1;
        #1;
        check("s5_in_ready", in_ready, 1);
        check("s5_w_valid", w_valid, 0);
        check("s5_w_word", w_word, 0);
        check("s5_w_index", w_index, 0);
        check("s5_busy", busy, 0);
        check("s5_done", done, 0);
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (70) @(negedge clk);
        check("s5_no_done", n_done - d0, 0);
        h0 = n_hs;
        load_block(abc_blk, 0, 1'b0, fv);
        drain(200);
        check("s5_reload_words", n_hs - h0, 64);
        check("s5_reload_done", n_done - d0, 1);
        check("s5_done_latency", done_cyc - fv, 64);

        // 6: back-to-back random blocks
        d0 = n_done; h0 = n_hs;
        load_block(rnd_a, 0, 1'b0, fv);
        drain(200);
        load_block(rnd_b, 0, 1'b0, fv);
        drain(200);
        check("s6_done_count", n_done - d0, 2);
        check("s6_word_count", n_hs - h0, 128);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- Sequential SHA-256 message-schedule generator.
- Accepts one 512-bit message block as 16 big-endian 32-bit words through a valid/ready input.
- Streams the 64 schedule words W[0..63] in order to the compression-round datapath through a valid/ready output.
- It is the producer side that consumes the small-sigma functions: W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16] mod 2^32.

Parameters:
- WORD_W, 32, schedule word width. Fixed for SHA-256; other values unsupported.
- NUM_WORDS, 64, number of schedule words emitted per block.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block can accept a message word.
- in_word  in  32  message word, M[0] first.
- w_valid  out  1  w_word/w_index are valid.
- w_ready  in  1  consumer accepts the current schedule word.
- w_word  out  32  schedule word W[w_index].
- w_index  out  6  round index t, 0..63.
- busy  out  1  high while streaming (STREAM state).
- done  out  1  one-cycle pulse after W[63] is accepted.

Behaviour:
- Reset is asynchronous; clk and rst are the only clock and reset. Reset values:
  - state=LOAD, load count=0, w_index=0.
  - All 16 window registers = 0.
  - in_ready=1, w_valid=0, w_word=0, busy=0, done=0.
- Storage: 16-entry window win[0..15] of 32-bit registers, plus a 4-bit load counter and a 6-bit round counter.
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- All additions are modulo 2^32, with carries discarded.
- State LOAD:
  - in_ready=1, w_valid=0.
  - On in_valid&in_ready, in_word is written to win[load_cnt] and load_cnt increments.
  - On acceptance of the 16th word (load_cnt=15), go to STREAM next cycle with load_cnt=0 and w_index=0.
  - in_valid with in_ready low is ignored (no capture).
- State STREAM:
  - in_ready=0, w_valid=1, busy=1.
  - w_word=win[0], driven directly from the register; w_index=round counter.
  - On w_valid&w_ready:
    - win[i] <= win[i+1] for i=0..14.
    - win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0].
    - w_index increments.
  - Without a handshake, all window registers, w_word and w_index hold (full backpressure stability).
  - On the handshake at w_index=63: go to LOAD and clear w_index to 0. done=1 for exactly the following cycle, coinciding with the first cycle of in_ready=1. The window contents are don't-care after this point.
- Throughput and latency:
  - One schedule word per cycle when w_ready is held high.
  - w_valid rises the cycle after the 16th input word is accepted.
  - Minimum block period is 16 + 64 = 80 cycles. Loading and streaming do not overlap.
- Precision: W[0..15] are emitted unchanged, and the expansion recurrence produces W[16..63] exactly. There is no separate path for t<16: the window shift handles both ranges uniformly.
- Reset mid-operation, in either state: returns immediately to reset values. Partial loads and in-flight streams are discarded, and no done pulse is generated.
- Simultaneous events: none are possible, because in_ready and w_valid are mutually exclusive by state.
- No combinational path from in_valid to in_ready or from w_ready to w_valid.

Test Plan:
1. "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready held high.
   - Requires w_valid on the cycle after the 16th accept.
   - W0..W15 echoed; W16=0x61626380 and W17=0x000F0000.
   - All 64 words must match the software model; done pulses once, 64 cycles after w_valid first rises.
2. Backpressure: same block, deassert w_ready for 3 cycles at w_index=5.
   - w_word stays 0x00000000 and w_index stays 5 through the stall.
   - The stream resumes with an identical sequence; the total count is exactly 64.
3. Input gaps: random in_valid bubbles during LOAD.
   - Exactly 16 words are captured in order.
   - Output is identical to scenario 1; in_valid while busy=1 is not captured.
4. Wrap/carry block: all 16 input words = 0xFFFFFFFF.
   - W16 = σ1(0xFFFFFFFF)+0xFFFFFFFF+σ0(0xFFFFFFFF)+0xFFFFFFFF = 0x003FFFFF+0xFFFFFFFF+0x1FFFFFFF+0xFFFFFFFF mod 2^32 = 0x203FFFFC.
   - Remaining words must match the model.
5. Reset mid-stream: assert rst asynchronously at w_index=30.
   - Outputs take reset values immediately; no done pulse.
   - A subsequent "abc" load reproduces scenario 1 exactly.
6. Back-to-back blocks: send a second, different block immediately after done.
   - in_ready is already high in the done cycle.
   - The second stream is correct and w_index restarts at 0.
